// File: rtl/window_average.sv
// Streaming 2x2 box-average over a raster-scanned frame, using one row of
// line buffer plus a two-pixel history to form each window.
module window_average #(
    parameter  int DATA_W = 8,
    parameter  int IMG_W  = 8,
    parameter  int IMG_H  = 16,
    parameter  int ROUND  = 0,
    localparam int COL_W  = $clog2(IMG_W),
    localparam int ROW_W  = $clog2(IMG_H),
    localparam int OCOL_W = (IMG_W - 1 > 1) ? $clog2(IMG_W - 1) : 1,
    localparam int OROW_W = (IMG_H - 1 > 1) ? $clog2(IMG_H - 1) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [OROW_W-1:0] out_row,
    output logic [OCOL_W-1:0] out_col,
    output logic              frame_done
);

    // Handshake: in_valid qualifies in_data and in_sof; there is no ready, so
    // every valid pixel is consumed on its clock edge. out_valid is a one-cycle
    // strobe for out_data/out_row/out_col with no backpressure from downstream.

    localparam int SUM_W = DATA_W + 2;
    localparam logic [SUM_W-1:0] RND = (ROUND != 0) ? SUM_W'(2) : '0;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  pix_col;
    logic [ROW_W-1:0]  pix_row;
    logic [COL_W-1:0]  col_nxt;
    logic [ROW_W-1:0]  row_nxt;
    logic              last_col;
    logic              last_row;
    logic              emit;

    logic [DATA_W-1:0] line_buf [IMG_W];
    logic [DATA_W-1:0] top;
    logic [DATA_W-1:0] left_cur;
    logic [DATA_W-1:0] left_top;
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] avg;

    // A start-of-frame pixel is forced to (0,0), abandoning any partial frame.
    always_comb begin
        pix_col  = in_sof ? '0 : col;
        pix_row  = in_sof ? '0 : row;
        last_col = (pix_col == COL_W'(IMG_W - 1));
        last_row = (pix_row == ROW_W'(IMG_H - 1));
        col_nxt  = last_col ? '0 : pix_col + 1'b1;
        if (last_col) begin
            row_nxt = last_row ? '0 : pix_row + 1'b1;
        end else begin
            row_nxt = pix_row;
        end
        emit = in_valid && (pix_row != '0) && (pix_col != '0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col <= '0;
            row <= '0;
        end else if (in_valid) begin
            col <= col_nxt;
            row <= row_nxt;
        end
    end

    // Window storage is never reset: row 0 emits nothing, so stale data is unused.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            line_buf[pix_col] <= in_data;
            left_cur          <= in_data;
            left_top          <= top;
        end
    end

    always_comb begin
        top = line_buf[pix_col];
        sum = {2'b00, left_top} + {2'b00, top} + {2'b00, left_cur}
            + {2'b00, in_data} + RND;
        avg = DATA_W'(sum >> 2);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            out_valid  <= emit;
            frame_done <= emit && last_row && last_col;
            if (emit) begin
                out_data <= avg;
                out_row  <= OROW_W'(pix_row - 1'b1);
                out_col  <= OCOL_W'(pix_col - 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_window_average.sv
// Bench for window_average: a 4x3 frame driven into truncating and rounding
// instances side by side, checked against a full-frame reference model.
module tb_window_average;

    localparam int DW  = 8;
    localparam int IW  = 4;
    localparam int IH  = 3;
    localparam int ORW = (IH - 1 > 1) ? $clog2(IH - 1) : 1;
    localparam int OCW = (IW - 1 > 1) ? $clog2(IW - 1) : 1;
    localparam int W   = DW + ORW + OCW + 1;

    logic           clk;
    logic           reset;
    logic           in_valid;
    logic           in_sof;
    logic [DW-1:0]  in_data;
    logic           out_valid0, out_valid1;
    logic [DW-1:0]  out_data0, out_data1;
    logic [ORW-1:0] out_row0, out_row1;
    logic [OCW-1:0] out_col0, out_col1;
    logic           frame_done0, frame_done1;

    window_average #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .ROUND(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .out_valid(out_valid0), .out_data(out_data0),
        .out_row(out_row0), .out_col(out_col0), .frame_done(frame_done0)
    );

    window_average #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH), .ROUND(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .out_valid(out_valid1), .out_data(out_data1),
        .out_row(out_row1), .out_col(out_col1), .frame_done(frame_done1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int           exp_t0[$];
    int           exp_t1[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           fd_cnt0 = 0;
    int           fd_cnt1 = 0;
    int           frames_exp = 0;
    int           img [IH][IW];
    int           mr = 0;
    int           mc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole frame kept in a 2D array, window read straight from it.
    task automatic model_pixel(input int d, input logic sof);
        int s;
        logic fd;
        logic [W-1:0] e;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = d;
        if (mr >= 1 && mc >= 1) begin
            s  = img[mr-1][mc-1] + img[mr-1][mc] + img[mr][mc-1] + d;
            fd = (mr == IH - 1) && (mc == IW - 1);
            if (fd) frames_exp++;
            e = {fd, ORW'(mr - 1), OCW'(mc - 1), DW'(s / 4)};
            exp_q0.push_back(e);
            exp_t0.push_back(cyc + 1);
            e = {fd, ORW'(mr - 1), OCW'(mc - 1), DW'((s + 2) / 4)};
            exp_q1.push_back(e);
            exp_t1.push_back(cyc + 1);
        end
        if (mc == IW - 1) begin
            mc = 0;
            mr = (mr == IH - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    // driver tasks
    task automatic drive_pixel(input int d, input logic sof);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = DW'(d);
        model_pixel(d, sof);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // kind 0: ramp 0..11, kind 1: all 255
    task automatic send_frame(input int kind, input int max_gap);
        for (int i = 0; i < IW * IH; i++) begin
            drive_pixel((kind == 0) ? i : 255, i == 0);
            if (max_gap > 0) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid0"}, out_valid0, 0);
        check({tag, "_data0"}, out_data0, 0);
        check({tag, "_row0"}, out_row0, 0);
        check({tag, "_col0"}, out_col0, 0);
        check({tag, "_fd0"}, frame_done0, 0);
        check({tag, "_valid1"}, out_valid1, 0);
        check({tag, "_data1"}, out_data1, 0);
        check({tag, "_row1"}, out_row1, 0);
        check({tag, "_col1"}, out_col1, 0);
        check({tag, "_fd1"}, frame_done1, 0);
    endtask

    task automatic score(input int id, input logic [W-1:0] got);
        logic [W-1:0] e;
        int t;
        int have;
        have = (id == 0) ? exp_q0.size() : exp_q1.size();
        check($sformatf("dut%0d_out_expected", id), 1, (have > 0) ? 1 : 0);
        if (have > 0) begin
            if (id == 0) begin
                e = exp_q0.pop_front();
                t = exp_t0.pop_front();
            end else begin
                e = exp_q1.pop_front();
                t = exp_t1.pop_front();
            end
            check($sformatf("dut%0d_result", id), 32'(got), 32'(e));
            check($sformatf("dut%0d_latency", id), cyc, t);
        end
    endtask

    // monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            if (out_valid0) score(0, {frame_done0, out_row0, out_col0, out_data0});
            else check("dut0_fd_idle", frame_done0, 0);
            if (out_valid1) score(1, {frame_done1, out_row1, out_col1, out_data1});
            else check("dut1_fd_idle", frame_done1, 0);
            if (frame_done0) fd_cnt0++;
            if (frame_done1) fd_cnt1++;
        end
    end

    initial begin
        int fd_base;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        #1;
        check_reset_state("init");
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        send_frame(0, 0);
        send_frame(1, 0);
        idle(2);
        send_frame(0, 3);
        send_frame(0, 3);
        idle(2);

        for (int i = 0; i < 6; i++) drive_pixel(i, i == 0);
        send_frame(0, 0);
        idle(2);

        for (int i = 0; i < 10; i++) drive_pixel(i, i == 0);
        idle(1);
        #2 reset = 1'b0;
        #1;
        check_reset_state("midrst");
        mr = 0;
        mc = 0;
        exp_q0.delete();
        exp_q1.delete();
        exp_t0.delete();
        exp_t1.delete();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        fd_base = fd_cnt0;
        send_frame(0, 0);
        send_frame(0, 0);
        idle(3);
        check("two_frames_fd", fd_cnt0 - fd_base, 2);

        check("fd_total0", fd_cnt0, frames_exp);
        check("fd_total1", fd_cnt1, frames_exp);
        check("drain0", exp_q0.size(), 0);
        check("drain1", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
